// File: rtl/gest_interrup_n.sv
// gest_interrup_n: N_CH-line edge-latched interrupt manager with fixed priority.
// Nested preemption (priority stack up to DEPTH) is built when GESTINT_NEST_EN is defined.
module gest_interrup_n #(
  parameter int              N_CH       = 4,
  parameter int              PC_W       = 10,
  parameter int              DEPTH      = 4,
  parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int              VEC_STRIDE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] irq,
  input  logic            en_we,
  input  logic [N_CH-1:0] en_d,
  input  logic            ack,
  input  logic            fin,
  output logic            int_req,
  output logic [PC_W-1:0] vector,
  output logic [3:0]      act_ch,
  output logic            busy,
  output logic [3:0]      level,
  output logic            fin_err
);

`ifdef GESTINT_NEST_EN
  localparam int EFF_DEPTH = DEPTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [3:0] stk [2**AW];
`else
  localparam int EFF_DEPTH = (DEPTH > 1) ? 1 : DEPTH;
`endif

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] irq_prev;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] clr;
  logic [3:0]      cand;
  logic [3:0]      pop_ch;
  logic            has_cand;
  logic            take;

  assign rise = irq & ~irq_prev;
  assign busy = |level;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i] && en[i]) begin
        has_cand = 1'b1;
        cand     = 4'(i);
      end
    end
  end

  always_comb begin
    int_req = has_cand && (level < 4'(EFF_DEPTH));
`ifdef GESTINT_NEST_EN
    int_req = int_req && (!busy || (cand < act_ch));
`else
    int_req = int_req && !busy;
`endif
  end

  assign vector = int_req
    ? PC_W'(32'(VEC_BASE) + 32'(cand) * 32'(VEC_STRIDE))
    : '0;

  // fin has precedence; an ack in the same cycle is dropped.
  assign take = ack && int_req && !fin;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr[i] = take && (cand == 4'(i));
    end
  end

`ifdef GESTINT_NEST_EN
  assign pop_ch = (level > 4'd1) ? stk[AW'(level - 4'd2)] : 4'd0;
`else
  assign pop_ch = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= '0;
      irq_prev <= '0;
      en       <= '1;
      level    <= '0;
      act_ch   <= '0;
      fin_err  <= 1'b0;
`ifdef GESTINT_NEST_EN
      for (int i = 0; i < 2**AW; i++) stk[i] <= '0;
`endif
    end else begin
      irq_prev <= irq;
      pend     <= (pend & ~clr) | rise;
      if (en_we) en <= en_d;
      if (fin) begin
        if (level == 4'd0) begin
          fin_err <= 1'b1;
        end else begin
          level  <= level - 4'd1;
          act_ch <= pop_ch;
        end
      end else if (take) begin
`ifdef GESTINT_NEST_EN
        if (busy) stk[AW'(level - 4'd1)] <= act_ch;
`endif
        act_ch <= cand;
        level  <= level + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_gest_interrup_n.sv
// tb_gest_interrup_n: directed plan plus random traffic against a queue-based model.
// Model follows GESTINT_NEST_EN the same way the design build does.
module tb_gest_interrup_n;
  localparam int N   = 4;
  localparam int DEP = 2;
`ifdef GESTINT_NEST_EN
  localparam int EFFD = DEP;
`else
  localparam int EFFD = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] irq;
  logic         en_we;
  logic [N-1:0] en_d;
  logic         ack;
  logic         fin;
  logic         int_req;
  logic [9:0]   vector;
  logic [3:0]   act_ch;
  logic         busy;
  logic [3:0]   level;
  logic         fin_err;

  gest_interrup_n #(
    .N_CH(N), .PC_W(10), .DEPTH(DEP),
    .VEC_BASE(10'h3C0), .VEC_STRIDE(8)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .en_we(en_we), .en_d(en_d), .ack(ack), .fin(fin),
    .int_req(int_req), .vector(vector), .act_ch(act_ch),
    .busy(busy), .level(level), .fin_err(fin_err)
  );

  int checks   = 0;
  int failures = 0;

  bit m_pend [N];
  bit m_en   [N];
  bit m_prev [N];
  bit m_ferr;
  int m_stk  [$];

  function automatic int m_cand();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic bit m_req();
    int c;
    c = m_cand();
    if (c < 0) return 1'b0;
    if (m_stk.size() >= EFFD) return 1'b0;
    if (m_stk.size() > 0 && c >= m_stk[$]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit r;
    int c;
    r = m_req();
    c = m_cand();
    chk("int_req", 32'(int_req), 32'(r));
    chk("vector", 32'(vector),
        r ? ((32'h3C0 + 32'(c) * 8) & 32'h3FF) : 32'h0);
    chk("busy", 32'(busy), 32'(m_stk.size() != 0));
    chk("level", 32'(level), 32'(m_stk.size()));
    chk("fin_err", 32'(fin_err), 32'(m_ferr));
    if (m_stk.size() != 0) chk("act_ch", 32'(act_ch), 32'(m_stk[$]));
  endtask

  task automatic m_update();
    bit r;
    int c;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
        m_en[i]   = 1'b1;
      end
      m_ferr = 1'b0;
      m_stk.delete();
    end else begin
      r = m_req();
      c = m_cand();
      if (fin) begin
        if (m_stk.size() == 0) m_ferr = 1'b1;
        else void'(m_stk.pop_back());
      end else if (ack && r) begin
        m_stk.push_back(c);
        m_pend[c] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
        m_prev[i] = irq[i];
        if (en_we) m_en[i] = en_d[i];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic step(input bit a, input bit f);
    ack = a;
    fin = f;
    cyc();
    ack   = 1'b0;
    fin   = 1'b0;
    en_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq = '0; en_we = 1'b0; en_d = '0;
    ack = 1'b0; fin = 1'b0;
    @(negedge clk);
    step(0, 0);
    step(0, 0);
    chk("rst_int_req", 32'(int_req), 32'h0);
    chk("rst_vector", 32'(vector), 32'h0);
    chk("rst_act_ch", 32'(act_ch), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    reset = 1'b1;

    irq = 4'b0100; step(0, 0);
    chk("t1_req", 32'(int_req), 32'h1);
    chk("t1_vec", 32'(vector), 32'h3D0);
    irq = '0; step(1, 0);
    chk("t1_act", 32'(act_ch), 32'h2);
    chk("t1_lvl", 32'(level), 32'h1);
    chk("t1_req_ack", 32'(int_req), 32'h0);
    step(0, 1);
    chk("t1_busy_fin", 32'(busy), 32'h0);

    irq = 4'b1010; step(0, 0);
    chk("t2_vec", 32'(vector), 32'h3C8);
    irq = '0; step(1, 0);
    step(0, 0);
    chk("t2_hold", 32'(int_req), 32'h0);
    step(0, 1);
    chk("t2_vec3", 32'(vector), 32'h3D8);
    step(1, 0);
    chk("t2_act3", 32'(act_ch), 32'h3);

    irq = 4'b0001; step(0, 0);
`ifdef GESTINT_NEST_EN
    chk("t3_req", 32'(int_req), 32'h1);
    chk("t3_vec", 32'(vector), 32'h3C0);
    irq = '0; step(1, 0);
    chk("t3_lvl2", 32'(level), 32'h2);
    chk("t3_act0", 32'(act_ch), 32'h0);
    step(0, 1);
    chk("t3_act3", 32'(act_ch), 32'h3);
    chk("t3_lvl1", 32'(level), 32'h1);
    step(0, 1);
`else
    chk("t3_noreq", 32'(int_req), 32'h0);
    irq = '0; step(1, 0);
    chk("t3_lvl1", 32'(level), 32'h1);
    step(0, 1);
    chk("t3_vec", 32'(vector), 32'h3C0);
    step(1, 0);
    step(0, 1);
`endif

    en_d = 4'b1011; en_we = 1'b1; step(0, 0);
    irq = 4'b0100; step(0, 0);
    chk("t4_masked", 32'(int_req), 32'h0);
    irq = '0; en_d = 4'hF; en_we = 1'b1; step(0, 0);
    chk("t4_unmask", 32'(int_req), 32'h1);
    chk("t4_vec", 32'(vector), 32'h3D0);
    step(1, 0);
    step(0, 1);

    irq = 4'b1000; step(0, 0);
    irq = '0; step(1, 0);
    irq = 4'b0100; step(0, 0);
    irq = '0; step(1, 0);
    irq = 4'b0010; step(0, 0);
    chk("t5_held", 32'(int_req), 32'h0);
    chk("t5_level", 32'(level), 32'(EFFD));
    reset = 1'b0; step(0, 0);
    chk("t6_req", 32'(int_req), 32'h0);
    chk("t6_lvl", 32'(level), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_act", 32'(act_ch), 32'h0);
    reset = 1'b1; irq = '0; step(0, 0);
    chk("t6_release", 32'(int_req), 32'h0);

    step(0, 1);
    chk("t7_ferr", 32'(fin_err), 32'h1);
    step(0, 0);
    chk("t7_sticky", 32'(fin_err), 32'h1);

    irq = 4'b0010; reset = 1'b0; step(0, 0);
    chk("t8_rst_req", 32'(int_req), 32'h0);
    chk("t8_ferr_clr", 32'(fin_err), 32'h0);
    reset = 1'b1; step(0, 0);
    chk("t8_high_rel", 32'(int_req), 32'h1);
    chk("t8_vec", 32'(vector), 32'h3C8);
    irq = '0; step(0, 0);
    irq = 4'b0010; step(1, 0);
    chk("t9_act1", 32'(act_ch), 32'h1);
    step(0, 1);
    chk("t9_repend", 32'(int_req), 32'h1);
    step(1, 1);
    chk("t9_finwins", 32'(level), 32'h0);
    chk("t9_still", 32'(int_req), 32'h1);

    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) != 0);
      irq   = irq ^ (N'($urandom) & N'($urandom));
      en_we = ($urandom_range(0, 9) == 0);
      en_d  = N'($urandom);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gest_interrup_n.md
# gest_interrup_n

Parametrised interrupt manager for the single-cycle CPU; successor of the fixed 4-port interrupt manager. It accepts N_CH interrupt lines, latches rising edges as pending requests and applies a per-channel enable mask and fixed priority. It supports nested preemption through an internal priority stack. It drives the interrupt request to the control unit (UC) and the vector multiplexed into the PC.

## Interface
- N_CH, 4: number of interrupt channels, 2..16; channel 0 has the highest priority.
- PC_W, 10: PC / vector width.
- DEPTH, 4: maximum nesting depth of in-service interrupts, 1..8.
- VEC_BASE, 10'h3C0: vector of channel 0.
- VEC_STRIDE, 8: vector spacing; vector(ch) = VEC_BASE + ch*VEC_STRIDE, truncated to PC_W bits.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- irq  in  N_CH  raw interrupt lines, synchronous to clk, level.
- en_we  in  1  write strobe for the enable mask.
- en_d  in  N_CH  new enable mask; bit = 1 enables the channel.
- ack  in  1  UC accepts the presented interrupt; this cycle PC loads vector.
- fin  in  1  end of service (return from interrupt).
- int_req  out  1  interrupt request to UC.
- vector  out  PC_W  target PC of the presented channel; 0 when int_req = 0.
- act_ch  out  4  channel currently in service; valid when busy = 1.
- busy  out  1  at least one interrupt in service.
- level  out  4  current nesting depth, 0..DEPTH.
- fin_err  out  1  sticky flag: fin was received with level = 0.

## Operation
- Edge detect: irq_prev register per channel. A channel's pending bit is set when irq = 1 and irq_prev = 0. Pending stays set until that channel is acknowledged; irq level afterwards is irrelevant.
- Candidate: the lowest-index channel with pending & en set. Masked pending bits are kept and become candidates when re-enabled.
- int_req = 1 when all of the following hold:
  - a candidate exists;
  - level < DEPTH;
  - busy = 0, or candidate index < act_ch (strictly higher priority).
- vector and the candidate index are driven from the same combinational decode.
- ack with int_req = 1, at the clock edge:
  - push act_ch (if busy) onto the stack;
  - act_ch <= candidate;
  - level + 1;
  - clear the candidate's pending bit.
- ack with int_req = 0: ignored.
- fin with level > 0: act_ch <= popped entry; level - 1; busy <= (level - 1 != 0).
- fin with level = 0: no state change; fin_err <= 1.
- Simultaneous events:
  - ack and fin in the same cycle: fin is processed and ack is ignored. The request stays presented if still eligible.
  - Edge on a channel being acknowledged in the same cycle: set wins, and the pending bit remains 1.
  - en_we in the same cycle as ack: ack uses the old mask.
- Pending bits of a lower priority than act_ch wait until the corresponding fin pops below them.

## Timing
- All outputs are combinational from registered state only; there is no combinational path from irq, ack or fin to any output.
- Latency: irq sampled low at edge k-1 and high at edge k gives pending = 1 and int_req = 1 after edge k, when eligible.
- After the ack edge: int_req reflects the new state in the next cycle. It drops unless another higher-priority candidate is eligible.
- Reset (reset = 0 at an edge):
  - pending = 0, irq_prev = 0, en = all ones;
  - stack cleared, level = 0, busy = 0, act_ch = 0, fin_err = 0;
  - therefore int_req = 0 and vector = 0.
- A line already high when reset releases counts as an edge at the first post-reset edge.
- Reset mid-service discards the whole stack and all pending bits.

## Configuration
- GESTINT_NEST_EN defined: nested preemption as above, up to DEPTH levels.
- GESTINT_NEST_EN undefined:
  - effective depth is 1, with no stack storage;
  - int_req requires busy = 0, so no preemption occurs;
  - fin returns to idle;
  - level is 0 or 1.

## Test plan
- Reset, then a rising edge on irq[2] -> int_req = 1 and vector = 10'h3D0 after the edge. ack -> busy = 1, act_ch = 2, level = 1, int_req = 0. fin -> busy = 0, level = 0.
- Simultaneous edges on irq[1] and irq[3] -> vector = 10'h3C8. After ack of channel 1, int_req stays 0 until fin, then vector = 10'h3D8.
- Nesting (NEST_EN): channel 3 in service, then an edge on irq[0] -> int_req = 1 and vector = 10'h3C0. ack -> level = 2, act_ch = 0. fin -> act_ch = 3, level = 1. Without the macro, int_req stays 0 until fin.
- Mask: en_d = 4'b1011 written, then an edge on irq[2] -> int_req = 0 and pending is held. Rewriting en_d = 4'hF -> int_req = 1 the next cycle.
- Depth and fin_err:
  - DEPTH = 2, channels 3, 2, 1 preempting in turn -> the third request is held with int_req = 0 at level = 2;
  - fin with level = 0 -> fin_err = 1, sticky until reset.
- Reset asserted with level = 2 and a pending bit set -> all outputs at their reset values after one edge. No int_req after release unless a line is high at release.
